// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the core's fetch/data ports, the shared memory
// and the arbiter. The arbiter sits on the slave modport; the core and
// memory model sit on the master modport.
//
// Handshakes: a requester raises its req together with its address and
// payload and holds them until the matching ready pulse; ready is a
// one-cycle pulse that marks completion (with err when the access was
// aborted). On the memory side mem_req is held with stable mem_* fields
// until mem_ack; mem_ack and mem_rdata are only meaningful while mem_req=1.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch port
    logic                i_req;
    logic [ADDR_W-1:0]   i_addr;
    logic                i_ready;
    logic [DATA_W-1:0]   i_rdata;
    logic                i_err;

    // Data port
    logic                d_req;
    logic                d_we;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W/8-1:0] d_mask;
    logic                d_ready;
    logic [DATA_W-1:0]   d_rdata;
    logic                d_err;

    // Hazard-unit stalls
    logic                stall_i;
    logic                stall_d;

    // Memory side
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_mask;
    logic                mem_ack;
    logic [DATA_W-1:0]   mem_rdata;

    // Arbiter view
    modport slave (
        input  i_req, i_addr,
        output i_ready, i_rdata, i_err,
        input  d_req, d_we, d_addr, d_wdata, d_mask,
        output d_ready, d_rdata, d_err,
        output stall_i, stall_d,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
        input  mem_ack, mem_rdata
    );

    // Core + memory view
    modport master (
        output i_req, i_addr,
        input  i_ready, i_rdata, i_err,
        output d_req, d_we, d_addr, d_wdata, d_mask,
        input  d_ready, d_rdata, d_err,
        input  stall_i, stall_d,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between the fetch port
// and the data port. One transaction is in flight at a time: IDLE picks a
// requester (round-robin on contention), BUSY holds the memory request
// until mem_ack or timeout, RESP pulses the winner's ready for one cycle.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus,
    output logic [1:0]           dbg_state
);
    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [DATA_W-1:0] ABORT_WORD = DATA_W'(32'hDEADBEEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    logic                grant_d;      // 1: data port owns the transaction
    logic                last_d;       // 1: data port was granted last
    logic [CNT_W-1:0]    tmo_cnt;

    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [MASK_W-1:0]   mem_mask_q;

    logic                i_ready_q;
    logic                d_ready_q;
    logic                i_err_q;
    logic                d_err_q;
    logic [DATA_W-1:0]   i_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;

    logic                pick_d;
    logic                timeout_hit;

    // Arbitration: a lone requester wins; on contention the port that did
    // not win last time goes first.
    always_comb begin
        pick_d = bus.d_req & (~bus.i_req | ~last_d);
    end

    // Abort when this BUSY cycle would bring the wait count up to TIMEOUT,
    // so mem_req stays high for exactly TIMEOUT cycles without an ack.
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && ((int'(tmo_cnt) + 1) >= TIMEOUT);
    end

    // Main controller: state, latched transaction and registered responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            grant_d     <= 1'b0;
            last_d      <= 1'b1;
            tmo_cnt     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_mask_q  <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_err_q     <= 1'b0;
            d_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        state     <= BUSY;
                        grant_d   <= pick_d;
                        last_d    <= pick_d;
                        tmo_cnt   <= '0;
                        mem_req_q <= 1'b1;
                        if (pick_d) begin
                            mem_we_q    <= bus.d_we;
                            mem_addr_q  <= bus.d_addr;
                            mem_wdata_q <= bus.d_wdata;
                            mem_mask_q  <= bus.d_mask;
                        end else begin
                            // Fetches are always plain reads
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= bus.i_addr;
                            mem_wdata_q <= '0;
                            mem_mask_q  <= '0;
                        end
                    end
                end

                BUSY: begin
                    if (bus.mem_ack) begin
                        state     <= RESP;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (grant_d) begin
                            d_ready_q <= 1'b1;
                            // Stores leave the load register untouched
                            if (!mem_we_q) begin
                                d_rdata_q <= bus.mem_rdata;
                            end
                        end else begin
                            i_ready_q <= 1'b1;
                            i_rdata_q <= bus.mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        state     <= RESP;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (grant_d) begin
                            d_ready_q <= 1'b1;
                            d_err_q   <= 1'b1;
                            d_rdata_q <= ABORT_WORD;
                        end else begin
                            i_ready_q <= 1'b1;
                            i_err_q   <= 1'b1;
                            i_rdata_q <= ABORT_WORD;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                RESP: begin
                    // Requests are not looked at here; a held req is
                    // treated as a fresh request once back in IDLE.
                    state     <= IDLE;
                    i_ready_q <= 1'b0;
                    d_ready_q <= 1'b0;
                    i_err_q   <= 1'b0;
                    d_err_q   <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state     = state;

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_mask  = mem_mask_q;

    assign bus.i_ready   = i_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.i_err     = i_err_q;
    assign bus.d_err     = d_err_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

    // Stalls are forced low while reset is asserted so the hazard unit
    // never sees a stall from a requester the arbiter is ignoring.
    assign bus.stall_i   = rst & bus.i_req & ~i_ready_q;
    assign bus.stall_d   = rst & bus.d_req & ~d_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model with programmable latency,
// table of single transactions, plus hand-written contention, timeout,
// protocol-violation and reset-in-flight sequences.
module tb_mem_port_arbiter;
    localparam int TB_TIMEOUT = 4;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         cyc;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_assert;
    int n_fail;
    logic [33:0] exp_q[$];      // {port_is_d, err, rdata}
    int          exp_cyc_q[$];  // expected cycles incl. request cycle, 0 = unchecked
    int          start_q[$];
    logic [68:0] exp_mem_q[$];  // {we, mask, addr, wdata}

    // memory model
    logic [31:0] mem_model[logic [31:0]];
    int          mem_lat;
    bit          mem_hang;
    int          mem_wait;

    task automatic chk(input string name, input logic [68:0] got, input logic [68:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Memory model: acks after mem_lat waiting cycles, applies byte-masked
    // writes, and checks the presented transaction at the ack cycle.
    always @(negedge clk) begin
        logic [31:0] cur;
        logic [68:0] e;
        if (!rst || !bus.mem_req || mem_hang) begin
            bus.mem_ack = 1'b0;
            mem_wait    = 0;
        end else if (mem_wait >= mem_lat) begin
            cur = mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr] : 32'h0;
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = cur;
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_mask[b]) cur[8*b +: 8] = bus.mem_wdata[8*b +: 8];
                end
                mem_model[bus.mem_addr] = cur;
            end
            if (exp_mem_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_mem_txn: addr=%0h with no transaction pending", bus.mem_addr);
            end else begin
                e = exp_mem_q.pop_front();
                chk("mem_txn_fields", {bus.mem_we, bus.mem_mask, bus.mem_addr, bus.mem_wdata}, e);
            end
            mem_wait = 0;
        end else begin
            bus.mem_ack = 1'b0;
            mem_wait++;
        end
    end

    // Response monitor: every ready pulse must match the head of exp_q.
    always @(negedge clk) begin
        logic [33:0] e;
        logic [33:0] got;
        int ec;
        int st;
        if (rst && (bus.i_ready || bus.d_ready)) begin
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_ready: i_ready=%0b d_ready=%0b with nothing pending", bus.i_ready, bus.d_ready);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                st = start_q.pop_front();
                if (bus.d_ready) got = {1'b1, bus.d_err, bus.d_rdata};
                else             got = {1'b0, bus.i_err, bus.i_rdata};
                chk("resp_port_err_rdata", got, e);
                chk("other_port_quiet", bus.d_ready ? {bus.i_ready, bus.i_err} : {bus.d_ready, bus.d_err}, 0);
                if (ec != 0) chk("ready_latency_cycles", cyc - st + 1, ec);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask, input int lat,
                          input logic [31:0] exp_rdata, input bit exp_err, input int exp_cycles,
                          input bit violate, input bit hang);
        bit stall_ok;
        bit done;
        bit rdy;
        bit stl;
        int req_cycles;
        @(negedge clk);
        mem_lat  = lat;
        mem_hang = hang;
        if (!hang) begin
            if (is_d) exp_mem_q.push_back({we, mask, addr, wdata});
            else      exp_mem_q.push_back({1'b0, 4'h0, addr, 32'h0});
        end
        exp_q.push_back({is_d, exp_err, exp_rdata});
        exp_cyc_q.push_back(exp_cycles);
        start_q.push_back(cyc);
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr;
            bus.d_wdata = wdata; bus.d_mask = mask;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        stall_ok = 1'b1;
        done = 1'b0;
        req_cycles = 0;
        for (int w = 0; w < 60 && !done; w++) begin
            @(negedge clk);
            if (bus.mem_req) req_cycles++;
            rdy = is_d ? bus.d_ready : bus.i_ready;
            stl = is_d ? bus.stall_d : bus.stall_i;
            if (rdy) begin
                done = 1'b1;
                if (stl) stall_ok = 1'b0;
            end else begin
                if (!stl) stall_ok = 1'b0;
                if (violate && w == 0) bus.d_addr = addr + 32'h10;
            end
        end
        chk("ready_seen", done, 1);
        chk("stall_until_ready", stall_ok, 1);
        if (hang) chk("timeout_mem_req_cycles", req_cycles, TB_TIMEOUT);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          lat;
        logic [31:0] exp_rdata;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[7];

    // ---------------- main sequence ----------------
    initial begin
        int n_rdy;
        vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        4'h0, 0, 32'h00500093, 3};
        vecs[1] = '{1'b1, 1'b1, 32'h40,  32'h12345678, 4'hF, 0, 32'h22222222, 3};
        vecs[2] = '{1'b1, 1'b0, 32'h40,  32'h0,        4'h0, 2, 32'h12345678, 5};
        vecs[3] = '{1'b1, 1'b1, 32'h40,  32'hAABBCCDD, 4'h5, 1, 32'h12345678, 4};
        vecs[4] = '{1'b1, 1'b0, 32'h40,  32'h0,        4'h0, 0, 32'h12BB56DD, 3};
        vecs[5] = '{1'b0, 1'b0, 32'h104, 32'h0,        4'h0, 3, 32'h11111111, 6};
        vecs[6] = '{1'b0, 1'b0, 32'h100, 32'h0,        4'h0, 1, 32'h00500093, 4};

        mem_model[32'h100] = 32'h00500093;
        mem_model[32'h104] = 32'h11111111;
        mem_model[32'h44]  = 32'h22222222;
        mem_model[32'h80]  = 32'hCAFEF00D;
        mem_model[32'h90]  = 32'h0BADF00D;

        n_assert = 0; n_fail = 0; cyc = 0;
        mem_lat = 0; mem_hang = 1'b0; mem_wait = 0;
        bus.mem_rdata = 32'h0;

        // Reset with both requesters already asserting (contention from reset)
        rst = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h104;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h44;
        bus.d_wdata = 32'h0; bus.d_mask = 4'h0;
        repeat (3) @(negedge clk);
        chk("reset_mem_side", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_mask}, 0);
        chk("reset_ready_err_stall", {bus.i_ready, bus.d_ready, bus.i_err, bus.d_err, bus.stall_i, bus.stall_d}, 0);
        chk("reset_rdata", {bus.i_rdata, bus.d_rdata}, 0);
        chk("reset_state", dbg_state, 0);

        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({1'b0, 1'b0, 32'h11111111}); exp_cyc_q.push_back(0); start_q.push_back(0);
            exp_mem_q.push_back({1'b0, 4'h0, 32'h104, 32'h0});
            exp_q.push_back({1'b1, 1'b0, 32'h22222222}); exp_cyc_q.push_back(0); start_q.push_back(0);
            exp_mem_q.push_back({1'b0, 4'h0, 32'h44, 32'h0});
        end
        rst = 1'b1;
        n_rdy = 0;
        for (int k = 0; k < 100 && n_rdy < 4; k++) begin
            @(negedge clk);
            if (bus.i_ready || bus.d_ready) n_rdy++;
        end
        chk("contention_four_grants", n_rdy, 4);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;

        // Table of single transactions
        for (int v = 0; v < 7; v++) begin
            do_req(vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].mask,
                   vecs[v].lat, vecs[v].exp_rdata, 1'b0, vecs[v].exp_cycles, 1'b0, 1'b0);
        end

        // Timeout: data read with no ack ever
        do_req(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b1, TB_TIMEOUT + 2, 1'b0, 1'b1);

        // Protocol violation: address changes while BUSY
        do_req(1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 2, 32'hCAFEF00D, 1'b0, 5, 1'b1, 1'b0);

        // Reset in the middle of a BUSY transaction
        @(negedge clk);
        mem_lat = 2; mem_hang = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h300;
        @(negedge clk);
        chk("busy_before_reset", {dbg_state, bus.mem_req}, {2'd1, 1'b1});
        #2 rst = 1'b0;
        #1;
        chk("async_reset_mem_side", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_mask}, 0);
        chk("async_reset_ready_err_stall", {bus.i_ready, bus.d_ready, bus.i_err, bus.d_err, bus.stall_i, bus.stall_d}, 0);
        chk("async_reset_rdata", {bus.i_rdata, bus.d_rdata}, 0);
        chk("async_reset_state", dbg_state, 0);
        bus.i_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_after_abandon", {dbg_state, bus.mem_req}, 0);

        // Fresh fetch after reset completes normally
        do_req(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 32'h00500093, 1'b0, 3, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("resp_queue_drained", exp_q.size(), 0);
        chk("mem_queue_drained", exp_mem_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global bound on the run
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the instruction-fetch port (IF stage) and the data port (MEM stage) of the pipelined core.
- Grants one requester at a time, latches its transaction and drives the memory-side handshake.
- Returns read data to the granted requester as a one-cycle ready pulse.
- Exports per-port stall signals to the hazard unit.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (mask width is DATA_W/8)
TIMEOUT, 255, maximum cycles waiting for mem_ack before abort; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
i_req  in  1  instruction read request, held until i_ready
i_addr  in  ADDR_W  fetch address
i_ready  out  1  one-cycle completion pulse for the instruction port
i_rdata  out  DATA_W  fetched word, registered
d_req  in  1  data request, held until d_ready
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_mask  in  DATA_W/8  byte write mask
d_ready  out  1  one-cycle completion pulse for the data port
d_rdata  out  DATA_W  load data, registered
d_err  out  1  asserted with d_ready when the transaction timed out
i_err  out  1  asserted with i_ready when the transaction timed out
stall_i  out  1  i_req & ~i_ready
stall_d  out  1  d_req & ~d_ready
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_mask  out  DATA_W/8  memory byte mask
mem_ack  in  1  memory completion; valid only while mem_req=1
mem_rdata  in  DATA_W  memory read data, valid with mem_ack

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; last_grant=D.
  - All outputs are 0: ready, err, mem_req, mem_we, mem_addr, mem_wdata, mem_mask, i_rdata, d_rdata, timeout counter.
  - Reset mid-transaction abandons the transaction; no ready pulse is issued afterwards.
- States: IDLE, BUSY, RESP.
- IDLE:
  - Samples the requests; if any is pending, goes to BUSY on the next edge.
  - Only d_req -> grant D. Only i_req -> grant I.
  - Both pending -> grant the port not equal to last_grant (round-robin), then update last_grant.
  - At grant, latches addr, we, wdata and mask into the mem_* registers; mem_req=1 from the BUSY cycle onward.
  - An instruction grant forces mem_we=0 and mem_mask=0.
- BUSY:
  - mem_* are held stable while mem_req=1.
  - mem_ack may arrive in the first BUSY cycle.
  - On mem_ack, the next edge sets mem_req=0 and mem_we=0 and moves to RESP.
  - On a read, mem_rdata is captured into the granted port's rdata register.
  - On a write, d_rdata holds its previous value.
  - Timeout counter:
    - Cleared on entry to BUSY and incremented each BUSY cycle without mem_ack.
    - When it reaches TIMEOUT (TIMEOUT≠0), the next edge drops mem_req, moves to RESP, sets the granted port's rdata=32'hDEADBEEF and raises its err.
- RESP:
  - Granted port's ready=1 (and err, if set) for exactly one cycle, then IDLE.
  - The requester's req is still high in RESP and is not re-sampled; it is sampled again only in IDLE.
  - The other port's ready is 0.
- Latency: minimum 3 cycles from req sampled to ready (IDLE -> BUSY with same-cycle ack -> RESP), plus N cycles for memory latency N.
- Back-to-back: a requester that keeps req high after ready is treated as a new request in the following IDLE cycle.
- Request dropped or changed during BUSY is a protocol violation. The latched transaction completes unchanged and the ready pulse is still issued.
- rdata outputs hold their value until that port's next read or timeout completion.
- stall_i and stall_d are combinational from req and ready. Both are 0 in reset.

Test Plan:
1. Single fetch: i_req=1, i_addr=0x100, mem_ack in the first BUSY cycle with mem_rdata=0x00500093 -> mem_addr=0x100, mem_we=0; i_ready pulses one cycle, 3 cycles after the request; i_rdata=0x00500093; stall_i is high until the pulse.
2. Store then load: d_we=1, d_addr=0x40, d_wdata=0x12345678, d_mask=0xF; then d_we=0 with 2-cycle memory latency returning 0x12345678 -> mem_mask=0xF, mem_we=1 on the first transaction only; the load's d_ready comes 5 cycles after its request; d_rdata=0x12345678.
3. Contention: i_req and d_req asserted together from reset and held continuously -> grant order D? No: last_grant resets to D, so the order is I, D, I, D. Ready pulses alternate, and no port waits more than one transaction.
4. Timeout: TIMEOUT=4, d read with mem_ack never asserted -> mem_req drops after 4 BUSY cycles; d_ready=1 and d_err=1 for one cycle; d_rdata=0xDEADBEEF; i_err=0.
5. Reset mid-BUSY: assert rst=0 during BUSY -> all outputs are 0 immediately, with no clock edge required; after release, no ready pulse for the abandoned transaction; a new i_req completes normally.
6. Protocol violation: change d_addr from 0x80 to 0x90 during BUSY -> mem_addr stays 0x80 and d_ready still pulses.
